input_loader: RTL and testbench

INPUT_LOADER -- requirements
Module: input_loader

---
 rtl/mm_pkg.sv | 21 ++
 rtl/input_loader.sv | 134 +++++++++++++
 tb/tb_input_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared constants for the matrix-multiply datapath: frame geometry, default
// RAM geometry and the input_loader state encoding.
package mm_pkg;

  localparam int NUMBER_OF_A_WORDS = 448;
  localparam int NUMBER_OF_B_WORDS = 8;
  localparam int NUMBER_OF_C_WORDS = 3;

  localparam int DEFAULT_WIDTH        = 8;
  localparam int DEFAULT_A_DEPTH_BITS = 9;
  localparam int DEFAULT_B_DEPTH_BITS = 3;
  localparam int DEFAULT_C_DEPTH_BITS = 2;

  localparam int LOADER_STATE_BITS = 3;
  localparam logic [LOADER_STATE_BITS-1:0] LOAD_A    = 3'd0;
  localparam logic [LOADER_STATE_BITS-1:0] LOAD_B    = 3'd1;
  localparam logic [LOADER_STATE_BITS-1:0] LOAD_C    = 3'd2;
  localparam logic [LOADER_STATE_BITS-1:0] FIRE      = 3'd3;
  localparam logic [LOADER_STATE_BITS-1:0] WAIT_DONE = 3'd4;

endpackage

// File: rtl/input_loader.sv
// Streams one 459-beat frame into the A, B and C RAMs, then pulses Start and
// waits for Done. Define INPUT_LOADER_TLAST_CHECK_EN to enable the sticky s_tlast framing check.
module input_loader
  import mm_pkg::*;
#(
  parameter int width        = DEFAULT_WIDTH,
  parameter int A_depth_bits = DEFAULT_A_DEPTH_BITS,
  parameter int B_depth_bits = DEFAULT_B_DEPTH_BITS,
  parameter int C_depth_bits = DEFAULT_C_DEPTH_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [width-1:0]        s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic                    A_write_en,
  output logic [A_depth_bits-1:0] A_write_address,
  output logic [width-1:0]        A_write_data_in,
  output logic                    B_write_en,
  output logic [B_depth_bits-1:0] B_write_address,
  output logic [width-1:0]        B_write_data_in,
  output logic                    C_write_en,
  output logic [C_depth_bits-1:0] C_write_address,
  output logic [width-1:0]        C_write_data_in,
  output logic                    Start,
  input  logic                    Done,
  output logic                    frame_error
);

  localparam logic [A_depth_bits-1:0] A_LAST = A_depth_bits'(NUMBER_OF_A_WORDS - 1);
  localparam logic [B_depth_bits-1:0] B_LAST = B_depth_bits'(NUMBER_OF_B_WORDS - 1);
  localparam logic [C_depth_bits-1:0] C_LAST = C_depth_bits'(NUMBER_OF_C_WORDS - 1);

  logic [LOADER_STATE_BITS-1:0] state, next_state;
  logic [A_depth_bits-1:0]      a_idx;
  logic [B_depth_bits-1:0]      b_idx;
  logic [C_depth_bits-1:0]      c_idx;
  logic                         c_done;
  logic                         accept;
  logic                         c_last_beat;
  logic                         tready_next;

  // LOAD_C lingers one cycle after the final beat (c_done) so that FIRE lands
  // in the cycle after the last C write.
  always_comb begin
    accept      = s_tvalid && s_tready;
    c_last_beat = (state == LOAD_C) && accept && (c_idx == C_LAST);
    next_state  = state;
    case (state)
      LOAD_A:    if (accept && (a_idx == A_LAST)) next_state = LOAD_B;
      LOAD_B:    if (accept && (b_idx == B_LAST)) next_state = LOAD_C;
      LOAD_C:    if (c_done) next_state = FIRE;
      FIRE:      next_state = WAIT_DONE;
      WAIT_DONE: if (Done) next_state = LOAD_A;
      default:   next_state = LOAD_A;
    endcase
    tready_next = (next_state == LOAD_A) || (next_state == LOAD_B) ||
                  ((next_state == LOAD_C) && !c_last_beat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= LOAD_A;
      s_tready        <= 1'b0;
      a_idx           <= '0;
      b_idx           <= '0;
      c_idx           <= '0;
      c_done          <= 1'b0;
      Start           <= 1'b0;
      A_write_en      <= 1'b0;
      A_write_address <= '0;
      A_write_data_in <= '0;
      B_write_en      <= 1'b0;
      B_write_address <= '0;
      B_write_data_in <= '0;
      C_write_en      <= 1'b0;
      C_write_address <= '0;
      C_write_data_in <= '0;
    end else begin
      state    <= next_state;
      s_tready <= tready_next;
      Start    <= (next_state == FIRE);
      c_done   <= c_last_beat;

      A_write_en <= accept && (state == LOAD_A);
      B_write_en <= accept && (state == LOAD_B);
      C_write_en <= accept && (state == LOAD_C);
      if (accept && (state == LOAD_A)) begin
        A_write_address <= a_idx;
        A_write_data_in <= s_tdata;
      end
      if (accept && (state == LOAD_B)) begin
        B_write_address <= b_idx;
        B_write_data_in <= s_tdata;
      end
      if (accept && (state == LOAD_C)) begin
        C_write_address <= c_idx;
        C_write_data_in <= s_tdata;
      end

      // Each index runs only while its state persists and clears on exit.
      if ((state == LOAD_A) && (next_state == LOAD_A))
        a_idx <= accept ? a_idx + A_depth_bits'(1) : a_idx;
      else
        a_idx <= '0;
      if ((state == LOAD_B) && (next_state == LOAD_B))
        b_idx <= accept ? b_idx + B_depth_bits'(1) : b_idx;
      else
        b_idx <= '0;
      if ((state == LOAD_C) && !c_last_beat)
        c_idx <= accept ? c_idx + C_depth_bits'(1) : c_idx;
      else
        c_idx <= '0;
    end
  end

`ifdef INPUT_LOADER_TLAST_CHECK_EN
  logic tlast_expected;
  assign tlast_expected = (state == LOAD_C) && (c_idx == C_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_error <= 1'b0;
    else if (accept && (s_tlast != tlast_expected))
      frame_error <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign frame_error  = 1'b0;
`endif

endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader: table of 459 frame beats with expected
// RAM writes, plus hand-written sequences for Done handshake, reset and tlast.
module tb_input_loader;

  localparam int FRAME = 459;
`ifdef INPUT_LOADER_TLAST_CHECK_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic       A_write_en, B_write_en, C_write_en;
  logic [8:0] A_write_address;
  logic [2:0] B_write_address;
  logic [1:0] C_write_address;
  logic [7:0] A_write_data_in, B_write_data_in, C_write_data_in;
  logic       Start;
  logic       Done = 1'b0;
  logic       frame_error;

  input_loader #(.width(8), .A_depth_bits(9), .B_depth_bits(3), .C_depth_bits(2)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .C_write_en(C_write_en), .C_write_address(C_write_address), .C_write_data_in(C_write_data_in),
    .Start(Start), .Done(Done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       tlast;
    int         ram;
    int         addr;
  } vec_t;

  vec_t vec[FRAME];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   exp_fe = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_writes(input bit pend, input vec_t pv);
    chk("A_write_en", A_write_en, int'(pend && pv.ram == 0));
    chk("B_write_en", B_write_en, int'(pend && pv.ram == 1));
    chk("C_write_en", C_write_en, int'(pend && pv.ram == 2));
    if (pend) begin
      case (pv.ram)
        0: begin
          chk("A_write_address", A_write_address, pv.addr);
          chk("A_write_data_in", A_write_data_in, pv.data);
        end
        1: begin
          chk("B_write_address", B_write_address, pv.addr);
          chk("B_write_data_in", B_write_data_in, pv.data);
        end
        default: begin
          chk("C_write_address", C_write_address, pv.addr);
          chk("C_write_data_in", C_write_data_in, pv.data);
        end
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_A_en"}, A_write_en, 0);
    chk({tag, "_A_addr"}, A_write_address, 0);
    chk({tag, "_A_data"}, A_write_data_in, 0);
    chk({tag, "_B_en"}, B_write_en, 0);
    chk({tag, "_B_addr"}, B_write_address, 0);
    chk({tag, "_B_data"}, B_write_data_in, 0);
    chk({tag, "_C_en"}, C_write_en, 0);
    chk({tag, "_C_addr"}, C_write_address, 0);
    chk({tag, "_C_data"}, C_write_data_in, 0);
    chk({tag, "_Start"}, Start, 0);
    chk({tag, "_frame_error"}, frame_error, 0);
  endtask

  // Feeds beats 0..stop-1 from the table, checking every cycle's write ports,
  // Start timing (two cycles after the final accepted beat) and frame_error.
  task automatic run_frame(input bit gaps, input int stop, input bit hold_after,
                           input int err_beat, input int done_cyc, input bit done_in_fire);
    int   idx = 0;
    int   cyc = 0;
    int   fin = -1;
    bit   pend = 1'b0;
    bit   fe_pend = 1'b0;
    vec_t pv = '{data: '0, tlast: 1'b0, ram: 0, addr: 0};
    while (cyc < 5000 && (idx < stop || pend || (stop == FRAME && fin < 3))) begin
      @(negedge clk);
      cyc++;
      if (fin >= 0) fin++;
      if (fe_pend) exp_fe = 1'b1;
      fe_pend = 1'b0;
      check_writes(pend, pv);
      chk("Start", Start, int'(fin == 2));
      chk("frame_error", frame_error, exp_fe);
      if (fin >= 1) chk("s_tready_after_last", s_tready, 0);
      Done = (cyc == done_cyc) || (done_in_fire && (fin == 1 || fin == 2));
      pend = 1'b0;
      if (idx < stop) begin
        s_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        s_tdata  = vec[idx].data;
        s_tlast  = vec[idx].tlast ^ (idx == err_beat);
        if (s_tvalid && s_tready) begin
          pend = 1'b1;
          pv   = vec[idx];
          if (idx == err_beat && FE_EN) fe_pend = 1'b1;
          idx++;
          if (idx == FRAME) fin = 0;
        end
      end else begin
        s_tvalid = hold_after;
        s_tdata  = 8'($urandom);
        s_tlast  = 1'b0;
      end
    end
    Done = 1'b0;
    if (cyc >= 5000) chk("frame_timeout", cyc, 0);
  endtask

  // WAIT_DONE: s_tvalid held high for 20 cycles, no acceptance until Done.
  task automatic post_frame();
    vec_t none = '{data: '0, tlast: 1'b0, ram: 0, addr: 0};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_writes(1'b0, none);
      chk("wait_s_tready", s_tready, 0);
      chk("wait_Start", Start, 0);
      s_tvalid = 1'b1;
      s_tdata  = 8'($urandom);
      Done     = (i == 19);
    end
    @(negedge clk);
    Done     = 1'b0;
    s_tvalid = 1'b0;
    chk("s_tready_after_Done", s_tready, 1);
    check_writes(1'b0, none);
  endtask

  initial begin
    for (int i = 0; i < FRAME; i++) begin
      vec[i].data  = 8'(i);
      vec[i].tlast = (i == FRAME - 1);
      if (i < 448) begin
        vec[i].ram = 0; vec[i].addr = i;
      end else if (i < 456) begin
        vec[i].ram = 1; vec[i].addr = i - 448;
      end else begin
        vec[i].ram = 2; vec[i].addr = i - 456;
      end
    end

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("s_tready_after_reset", s_tready, 1);

    run_frame(1'b0, FRAME, 1'b1, -1, -1, 1'b1);
    post_frame();
    run_frame(1'b1, FRAME, 1'b0, -1, 50, 1'b0);
    post_frame();
    run_frame(1'b0, FRAME, 1'b0, 100, -1, 1'b0);
    post_frame();
    chk("frame_error_sticky", frame_error, int'(FE_EN));

    run_frame(1'b0, 301, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    exp_fe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s_tready_after_reset2", s_tready, 1);
    run_frame(1'b0, FRAME, 1'b0, -1, -1, 1'b0);
    chk("frame_error_clean", frame_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
